lfsr_seq_ctrl: RTL and testbench
================================

# lfsr_seq_ctrl

Sequencing controller for the team's serial-seeded LFSR. It accepts a seed word over a valid/ready request channel and drives the LFSR's `ena`/`seed` pins to shift the seed in serially. It then lets the LFSR free-run for a fixed number of cycles while capturing its `out` bit stream into a parallel word. The word is returned over a valid/ready response channel. It sits between a software-visible register block and one LFSR instance.

## Interface
- `LFSR_LEN`, default 3: number of LFSR stages, which equals the number of seed bits loaded.
- `OUT_BITS`, default 8: number of output bits captured per request.
- `DEFAULT_SEED`, default `3'b011`: substitute seed, used only when `LFSR_SEQ_ZERO_GUARD_EN` is defined.
- `clk` in 1: single clock, posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_seed` in `LFSR_LEN`: seed word.
- `rsp_valid` out 1: captured word available.
- `rsp_ready` in 1: consumer takes the word.
- `rsp_data` out `OUT_BITS`: captured bit stream.
- `lfsr_ena` out 1: drives the LFSR `ena` pin.
- `lfsr_seed` out 1: drives the LFSR `seed` pin.
- `lfsr_out` in 1: driven by the LFSR `out` pin.
- `busy` out 1: high in LOAD or RUN.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch `req_seed` into the seed shift register, clear the counter, go to LOAD.
- **LOAD**
  - Lasts `LFSR_LEN` cycles.
  - `lfsr_ena` = 1.
  - `lfsr_seed` = current MSB of the seed shift register, so bits are applied MSB first.
  - The seed shift register shifts left each cycle.
  - When the counter reaches `LFSR_LEN-1`: clear the counter, go to RUN.
- **RUN**
  - Lasts `OUT_BITS` cycles.
  - `lfsr_ena` = 0, so the LFSR free-runs.
  - Each edge: `rsp_data <= {rsp_data[OUT_BITS-2:0], lfsr_out}`. The first captured bit ends in the MSB.
  - When the counter reaches `OUT_BITS-1`: go to DONE.
- **DONE**
  - `rsp_valid` = 1; `rsp_data` is held stable.
  - On `rsp_valid & rsp_ready`: go to IDLE.
- Decode rules:
  - `req_ready`, `lfsr_ena`, `lfsr_seed` and `busy` are combinational decodes of the state.
  - `rsp_valid` is registered.
  - `lfsr_seed` = 0 outside LOAD.
- The counter is `$clog2(max(LFSR_LEN, OUT_BITS))` bits wide. It never wraps: exit is by compare.
- `rsp_data` is not cleared on accept. It is fully overwritten by the `OUT_BITS` RUN shifts.

## Timing
- Reset values while `rst` is low:
  - state = IDLE
  - `req_ready` = 1
  - `rsp_valid` = 0
  - `rsp_data` = 0
  - `lfsr_ena` = 0
  - `lfsr_seed` = 0
  - `busy` = 0
  - counter = 0
  - seed shift register = 0
- Reset mid-operation:
  - All outputs take their reset values immediately, asynchronously.
  - Any in-flight request is dropped.
  - The LFSR contents are don't-care; the next request reseeds them.
- Latency:
  - Request accepted at edge E0.
  - `rsp_valid` rises after edge E0 + `LFSR_LEN` + `OUT_BITS`, which is 11 edges with the defaults.
- Response handshake:
  - `rsp_valid` and `rsp_data` hold until `rsp_ready` is sampled high.
  - The handshake edge returns the controller to IDLE.
  - No request can be accepted on the handshake edge itself, because `req_ready` = 0 in DONE.
- Back-to-back throughput: minimum accept-to-accept spacing is `LFSR_LEN` + `OUT_BITS` + 2 edges, which is 13 with the defaults.
- `req_valid` asserted outside IDLE is ignored. The requester holds it until `req_ready`.

## Configuration
- Macro: `LFSR_SEQ_ZERO_GUARD_EN`.
- Defined: a `req_seed` of all zeros is replaced by `DEFAULT_SEED` at accept time. This avoids the all-zero LFSR lock-up state.
- Undefined: the seed is used verbatim. An all-zero seed yields an all-zero `rsp_data`.

## Structure
- Shared package `lfsr_seq_pkg` holds:
  - the state enum `lfsr_seq_state_t` (IDLE, LOAD, RUN, DONE);
  - the default parameter constants.
- No sub-module. Counter, seed shift register and capture shift register stay inline.
- The LFSR itself is instantiated by the parent, not inside this block.

## Test plan
Bench setup: the controller drives the team's 3-stage LFSR, with `s0 <= s0^s1`, `s1 <= s0`, `s2 <= s1`, `out = s2`, defaults throughout.
- **Reset:** hold `rst` low 3 cycles, then release → `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0x00, `lfsr_ena` = 0, `busy` = 0.
- **Single request:** `req_seed` = 3'b011 → `lfsr_ena` high 3 cycles with `lfsr_seed` = 0, 1, 1; then `rsp_valid` high 11 edges after accept with `rsp_data` = 0x6D.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles after `rsp_valid` while `req_valid` stays high → `rsp_data` holds 0x6D, `req_ready` = 0, no second accept. Raise `rsp_ready` → IDLE on the next edge.
- **Back-to-back:** hold `req_valid` and `rsp_ready` high with seed 3'b011 → accepts exactly 13 edges apart, each response 0x6D.
- **Zero seed:** `req_seed` = 0 → 0x6D with `LFSR_SEQ_ZERO_GUARD_EN` defined; 0x00 without it.
- **Reset mid-RUN:** drive `rst` low at RUN cycle 4 → `busy` and `lfsr_ena` drop immediately, `rsp_valid` stays 0. A fresh request with seed 3'b011 returns 0x6D.

Source files
------------

// File: rtl/lfsr_seq_pkg.sv
// ============================================================================
// Module   : lfsr_seq_pkg
// Brief    : Shared state encoding and default constants for lfsr_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } lfsr_seq_state_t;

  localparam int         c_lfsr_len_default = 3;
  localparam int         c_out_bits_default = 8;
  localparam logic [2:0] c_default_seed     = 3'b011;

  // One counter serves both phases, so it is sized for the longer one.
  function automatic int lfsr_seq_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
// ============================================================================
// Module   : lfsr_seq_ctrl
// Brief    : Serially seeds an external LFSR, then captures OUT_BITS of its
//            output stream and returns them over a valid/ready channel.
//            Optional macro LFSR_SEQ_ZERO_GUARD_EN swaps an all-zero seed for
//            DEFAULT_SEED at accept time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_seq_ctrl
  import lfsr_seq_pkg::*;
#(
  parameter int                  LFSR_LEN     = c_lfsr_len_default,
  parameter int                  OUT_BITS     = c_out_bits_default,
  parameter logic [LFSR_LEN-1:0] DEFAULT_SEED = LFSR_LEN'(c_default_seed)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LFSR_LEN-1:0] req_seed,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OUT_BITS-1:0] rsp_data,
  output logic                lfsr_ena,
  output logic                lfsr_seed,
  input  logic                lfsr_out,
  output logic                busy
);

  localparam int c_cnt_w = lfsr_seq_cnt_w(LFSR_LEN, OUT_BITS);

  localparam logic [c_cnt_w-1:0] c_load_last = c_cnt_w'(LFSR_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_run_last  = c_cnt_w'(OUT_BITS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

`ifdef LFSR_SEQ_ZERO_GUARD_EN
  localparam bit c_zero_guard = 1'b1;
`else
  localparam bit c_zero_guard = 1'b0;
`endif

  lfsr_seq_state_t r_state;
  lfsr_seq_state_t w_state_nxt;

  logic [c_cnt_w-1:0]  r_cnt;
  logic [LFSR_LEN-1:0] r_seed_sr;
  logic [OUT_BITS-1:0] r_rsp_data;
  logic                r_rsp_valid;

  logic                w_load_last;
  logic                w_run_last;
  logic [LFSR_LEN-1:0] w_seed_in;

  assign w_load_last = (r_cnt == c_load_last);
  assign w_run_last  = (r_cnt == c_run_last);

  // An all-zero seed would lock the LFSR, so the guard substitutes a safe one.
  assign w_seed_in = (c_zero_guard && (req_seed == '0)) ? DEFAULT_SEED : req_seed;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    lfsr_ena    = 1'b0;
    lfsr_seed   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        lfsr_ena  = 1'b1;
        lfsr_seed = r_seed_sr[LFSR_LEN-1];
        if (w_load_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_run_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (r_rsp_valid && rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: counter, seed shifter and capture shifter, all keyed off state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_seed_sr   <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_seed_sr <= w_seed_in;
            r_cnt     <= '0;
          end
        end
        LOAD: begin
          r_seed_sr <= r_seed_sr << 1;
          if (w_load_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        RUN: begin
          r_rsp_data <= {r_rsp_data[OUT_BITS-2:0], lfsr_out};
          if (w_run_last) begin
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
// ============================================================================
// Module   : tb_lfsr_seq_ctrl
// Brief    : Self-checking bench for lfsr_seq_ctrl driving a 3-stage LFSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_seed = 3'b000;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       lfsr_ena;
  logic       lfsr_seed;
  logic       lfsr_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seed  (req_seed),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .lfsr_ena  (lfsr_ena),
    .lfsr_seed (lfsr_seed),
    .lfsr_out  (lfsr_out),
    .busy      (busy)
  );

  // Team 3-stage LFSR: serial load while ena, free-run otherwise.
  logic s0 = 1'b0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  assign lfsr_out = s2;
  always_ff @(posedge clk) begin
    if (lfsr_ena) begin
      s0 <= lfsr_seed;
    end else begin
      s0 <= s0 ^ s1;
    end
    s1 <= s0;
    s2 <= s1;
  end

  typedef struct {
    logic [2:0] seed;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [2:0] seed, input logic [7:0] exp, input string name);
    int  k;
    bit  early;
    req_seed  = seed;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check({name, " req_ready"}, 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check({name, " load ena"}, 32'(lfsr_ena), 1);
      check({name, " load seed bit"}, 32'(lfsr_seed), 32'(seed[2-b]));
      tick();
    end
    early = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid || lfsr_ena || !busy) early = 1'b1;
      tick();
    end
    check({name, " run phase"}, 32'(early), 0);
    check({name, " rsp_valid"}, 32'(rsp_valid), 1);
    check({name, " rsp_data"}, 32'(rsp_data), 32'(exp));
    check({name, " done busy"}, 32'(busy), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, " back idle"}, 32'({req_ready, rsp_valid, busy}), 32'(3'b100));
  endtask

  initial begin
    int   acc_t[3];
    int   n_acc;
    int   cyc;
    logic [7:0] zero_exp;

`ifdef LFSR_SEQ_ZERO_GUARD_EN
    zero_exp = 8'h6D;
`else
    zero_exp = 8'h00;
`endif
    vecs[0] = '{seed: 3'b011, exp: 8'h6D};
    vecs[1] = '{seed: 3'b001, exp: 8'h36};
    vecs[2] = '{seed: 3'b100, exp: 8'h80};
    vecs[3] = '{seed: 3'b111, exp: 8'hED};
    vecs[4] = '{seed: 3'b010, exp: 8'h5B};
    vecs[5] = '{seed: 3'b110, exp: 8'hDB};
    vecs[6] = '{seed: 3'b101, exp: 8'hB6};
    vecs[7] = '{seed: 3'b000, exp: zero_exp};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("in reset outputs", 32'({req_ready, rsp_valid, lfsr_ena, lfsr_seed, busy}), 32'(5'b10000));
    rst = 1'b1;
    tick();
    check("reset req_ready", 32'(req_ready), 1);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_data", 32'(rsp_data), 0);
    check("reset lfsr_ena", 32'(lfsr_ena), 0);
    check("reset busy", 32'(busy), 0);

    // Table-driven single requests
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].seed, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: response held, further requests ignored
    do_req(3'b011, 8'h6D, "bp prep");
    req_seed  = 3'b011;
    req_valid = 1'b1;
    tick();
    for (int c = 0; c < 10 && !rsp_valid; c++) tick();
    for (int c = 0; c < 10 && !rsp_valid; c++) tick();
    check("bp rsp_valid", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      check("bp hold data", 32'(rsp_data), 32'(8'h6D));
      check("bp hold valid/ready", 32'({rsp_valid, req_ready}), 32'(2'b10));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("bp release idle", 32'({req_ready, rsp_valid, busy}), 32'(3'b100));

    // Back-to-back throughput
    req_seed  = 3'b011;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    n_acc = 0;
    cyc = 0;
    while (cyc < 80 && n_acc < 3) begin
      if (req_ready) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (rsp_valid) check("b2b rsp_data", 32'(rsp_data), 32'(8'h6D));
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    check("b2b accepts", 32'(n_acc), 3);
    if (n_acc == 3) begin
      check("b2b spacing 1", 32'(acc_t[1] - acc_t[0]), 13);
      check("b2b spacing 2", 32'(acc_t[2] - acc_t[1]), 13);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    check("b2b last valid", 32'(rsp_valid), 1);
    check("b2b last data", 32'(rsp_data), 32'(8'h6D));
    tick();
    rsp_ready = 1'b0;
    check("b2b end idle", 32'({req_ready, rsp_valid}), 32'(2'b10));

    // Reset mid-RUN (4th RUN cycle)
    req_seed  = 3'b011;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrun busy", 32'(busy), 0);
    check("midrun lfsr_ena", 32'(lfsr_ena), 0);
    check("midrun rsp_valid", 32'(rsp_valid), 0);
    check("midrun req_ready", 32'(req_ready), 1);
    check("midrun rsp_data", 32'(rsp_data), 0);
    repeat (2) tick();
    check("midrun held valid", 32'(rsp_valid), 0);
    rst = 1'b1;
    tick();
    do_req(3'b011, 8'h6D, "after midrun");

    // Reset mid-LOAD
    req_seed  = 3'b011;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("midload ena before", 32'(lfsr_ena), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midload ena drop", 32'({lfsr_ena, lfsr_seed, busy}), 0);
    tick();
    rst = 1'b1;
    tick();
    do_req(3'b011, 8'h6D, "after midload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
